// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage front end. Issues instruction-memory read requests, holds the
// returned word for decode, and follows branch/jump redirects. If a redirect
// arrives while a read is still outstanding, that read is drained in the
// DISCARD state. Its data is never used. The new target is fetched only
// after the memory has acknowledged the stale read.
//
// Ports
//   clk         in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high reset
//   imemReq     out  1   instruction-memory read request
//   imemAddr    out  32  byte address of the request
//   imemAck     in   1   imemData valid for the current request
//   imemData    in   32  instruction word returned by memory
//   redirect    in   1   taken branch/jump: refetch from redirectPc
//   redirectPc  in   32  redirect target (bits [1:0] ignored)
//   stall       in   1   decode cannot accept the held instruction
//   instr       out  32  held instruction word
//   instrValid  out  1   instr is valid for decode
//   pcOut       out  32  byte address of instr
//   opcode      out  6   instr[31:26]
//   funct       out  6   instr[5:0]
//   fetchCount  out  32  instructions consumed by decode (wraps)
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemAck,
   input  logic [31:0] imemData,
   input  logic        redirect,
   input  logic [31:0] redirectPc,
   input  logic        stall,
   output logic [31:0] instr,
   output logic        instrValid,
   output logic [31:0] pcOut,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] fetchCount
);

   typedef enum logic [1:0] {
      S_REQ,      // request outstanding at pc
      S_VALID,    // instruction held for decode
      S_DISCARD   // stale request outstanding at stale_addr
   } state_t;

   state_t      state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic [31:0] stale_addr_q, stale_addr_d;
   logic [31:0] instr_q,      instr_d;
   logic [31:0] pc_out_q,     pc_out_d;
   logic        valid_q,      valid_d;
   logic [31:0] count_q,      count_d;

   // Redirect targets are always word aligned.
   logic [31:0] redirect_tgt;
   assign redirect_tgt = redirectPc & 32'hFFFF_FFFC;

   // NOTE: every variable gets its hold value first, so any path that does not
   // assign a variable keeps its current value and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stale_addr_d = stale_addr_q;
      instr_d      = instr_q;
      pc_out_d     = pc_out_q;
      valid_d      = valid_q;
      count_d      = count_q;

      case (state_q)
         S_REQ: begin
            if (imemAck) begin
               if (redirect) begin
                  // The returned word is on the wrong path. Drop it and
                  // request the target next cycle.
                  pc_d = redirect_tgt;
               end else begin
                  instr_d  = imemData;
                  pc_out_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  valid_d  = 1'b1;
                  state_d  = S_VALID;
               end
            end else if (redirect) begin
               // The memory still owes us a response for pc. Keep presenting
               // that address until it acknowledges.
               stale_addr_d = pc_q;
               pc_d         = redirect_tgt;
               state_d      = S_DISCARD;
            end
         end

         S_DISCARD: begin
            if (redirect) begin
               pc_d = redirect_tgt;
            end
            if (imemAck) begin
               state_d = S_REQ;
            end
         end

         S_VALID: begin
            if (redirect) begin
               // A redirect overrides stall. The held instruction is on the
               // wrong path.
               valid_d = 1'b0;
               pc_d    = redirect_tgt;
               state_d = S_REQ;
            end else if (!stall) begin
               count_d = count_q + 32'd1;
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         stale_addr_q <= RESET_PC;
         instr_q      <= 32'h0000_0000;
         pc_out_q     <= RESET_PC;
         valid_q      <= 1'b0;
         count_q      <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_addr_q <= stale_addr_d;
         instr_q      <= instr_d;
         pc_out_q     <= pc_out_d;
         valid_q      <= valid_d;
         count_q      <= count_d;
      end
   end

   // Reset gates the request combinationally. This prevents a request from
   // leaking out during the first reset cycle, before the state register has
   // been cleared.
   assign imemReq    = !reset && (state_q != S_VALID);
   assign imemAddr   = (state_q == S_DISCARD) ? stale_addr_q : pc_q;
   assign instr      = instr_q;
   assign instrValid = valid_q;
   assign pcOut      = pc_out_q;
   assign opcode     = instr_q[31:26];
   assign funct      = instr_q[5:0];
   assign fetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. Memory responses are driven by hand,
// cycle by cycle. Each returned word is derived from its address
// (addr ^ 32'h20), so address 0 yields 32'h0000_0020.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemAck;
   logic [31:0] imemData;
   logic        redirect;
   logic [31:0] redirectPc;
   logic        stall;
   logic [31:0] instr;
   logic        instrValid;
   logic [31:0] pcOut;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] fetchCount;

   int n_checks = 0;
   int n_errors = 0;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemAck    (imemAck),
      .imemData   (imemData),
      .redirect   (redirect),
      .redirectPc (redirectPc),
      .stall      (stall),
      .instr      (instr),
      .instrValid (instrValid),
      .pcOut      (pcOut),
      .opcode     (opcode),
      .funct      (funct),
      .fetchCount (fetchCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return addr ^ 32'h0000_0020;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      imemAck    = 1'b0;
      imemData   = 32'h0;
      redirect   = 1'b0;
      redirectPc = 32'h0;
      stall      = 1'b1;
      tick();
      tick();

      // Reset state
      check("rst_req",    {31'd0, imemReq},    32'd0);
      check("rst_valid",  {31'd0, instrValid}, 32'd0);
      check("rst_instr",  instr,               32'h0);
      check("rst_pcout",  pcOut,               32'h0);
      check("rst_count",  fetchCount,          32'd0);

      // 1-cycle latency fetch at 0, consumed immediately
      reset = 1'b0;
      stall = 1'b0;
      #1;
      check("f0_req",  {31'd0, imemReq}, 32'd1);
      check("f0_addr", imemAddr,         32'h0);
      imemAck  = 1'b1;
      imemData = mem_word(32'h0);
      tick();
      imemAck = 1'b0;
      check("f0_valid",  {31'd0, instrValid}, 32'd1);
      check("f0_instr",  instr,               32'h0000_0020);
      check("f0_opcode", {26'd0, opcode},     32'd0);
      check("f0_funct",  {26'd0, funct},      32'd32);
      check("f0_pcout",  pcOut,               32'h0);
      check("f0_vreq",   {31'd0, imemReq},    32'd0);
      tick();
      check("f0_next_addr", imemAddr,           32'h4);
      check("f0_count",     fetchCount,         32'd1);
      check("f0_cleared",   {31'd0, instrValid}, 32'd0);

      // Hold the instruction at 4 under stall for three cycles
      imemAck  = 1'b1;
      imemData = mem_word(32'h4);
      stall    = 1'b1;
      tick();
      imemAck = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_valid", {31'd0, instrValid}, 32'd1);
         check("stall_instr", instr,               32'h0000_0024);
         check("stall_pcout", pcOut,               32'h4);
         check("stall_req",   {31'd0, imemReq},    32'd0);
         check("stall_count", fetchCount,          32'd1);
         tick();
      end
      stall = 1'b0;
      tick();
      check("unstall_valid", {31'd0, instrValid}, 32'd0);
      check("unstall_count", fetchCount,          32'd2);
      check("unstall_addr",  imemAddr,            32'h8);

      // Redirect during a 3-cycle fetch at 8; the late data must be dropped
      redirect   = 1'b1;
      redirectPc = 32'h0000_0043;
      tick();
      redirect = 1'b0;
      check("disc_addr1",  imemAddr,            32'h8);
      check("disc_req1",   {31'd0, imemReq},    32'd1);
      check("disc_valid1", {31'd0, instrValid}, 32'd0);
      tick();
      check("disc_addr2",  imemAddr,            32'h8);
      check("disc_valid2", {31'd0, instrValid}, 32'd0);
      imemAck  = 1'b1;
      imemData = 32'hDEAD_BEEF;
      tick();
      imemAck = 1'b0;
      check("disc_new_addr", imemAddr,            32'h40);
      check("disc_valid3",   {31'd0, instrValid}, 32'd0);
      check("disc_instr",    instr,               32'h0000_0024);
      check("disc_count",    fetchCount,          32'd2);

      // Stall and redirect together while holding the instruction at 0x40
      imemAck  = 1'b1;
      imemData = mem_word(32'h40);
      tick();
      imemAck = 1'b0;
      check("v40_valid", {31'd0, instrValid}, 32'd1);
      check("v40_instr", instr,               32'h0000_0060);
      check("v40_pcout", pcOut,               32'h40);
      stall      = 1'b1;
      redirect   = 1'b1;
      redirectPc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      stall    = 1'b0;
      check("sr_valid", {31'd0, instrValid}, 32'd0);
      check("sr_addr",  imemAddr,            32'h100);
      check("sr_count", fetchCount,          32'd2);

      // Ack and redirect in the same REQ cycle: drop data and stay in REQ
      imemAck    = 1'b1;
      imemData   = mem_word(32'h100);
      redirect   = 1'b1;
      redirectPc = 32'hFFFF_FFFE;
      tick();
      imemAck  = 1'b0;
      redirect = 1'b0;
      check("ackredir_valid", {31'd0, instrValid}, 32'd0);
      check("ackredir_req",   {31'd0, imemReq},    32'd1);
      check("ackredir_addr",  imemAddr,            32'hFFFF_FFFC);

      // PC wraps to 0 after a fetch at the top of the address space
      imemAck  = 1'b1;
      imemData = mem_word(32'hFFFF_FFFC);
      tick();
      imemAck = 1'b0;
      check("wrap_instr",  instr,           32'hFFFF_FFDC);
      check("wrap_opcode", {26'd0, opcode}, 32'h3F);
      check("wrap_funct",  {26'd0, funct},  32'h1C);
      check("wrap_pcout",  pcOut,           32'hFFFF_FFFC);
      tick();
      check("wrap_addr",  imemAddr,   32'h0);
      check("wrap_count", fetchCount, 32'd3);

      // DISCARD: a later redirect wins over an earlier one
      redirect   = 1'b1;
      redirectPc = 32'h0000_0200;
      tick();
      check("latest_stale1", imemAddr, 32'h0);
      redirectPc = 32'h0000_0300;
      tick();
      redirect = 1'b0;
      check("latest_stale2", imemAddr, 32'h0);
      imemAck = 1'b1;
      tick();
      imemAck = 1'b0;
      check("latest_addr", imemAddr, 32'h300);

      // Reset asserted while in DISCARD, with a colliding ack
      redirect   = 1'b1;
      redirectPc = 32'h0000_0200;
      tick();
      redirect = 1'b0;
      check("pre_rst_stale", imemAddr, 32'h300);
      reset   = 1'b1;
      imemAck = 1'b1;
      #1;
      check("rst_req_forced", {31'd0, imemReq}, 32'd0);
      tick();
      imemAck = 1'b0;
      check("rst2_req",   {31'd0, imemReq},    32'd0);
      check("rst2_valid", {31'd0, instrValid}, 32'd0);
      check("rst2_instr", instr,               32'h0);
      check("rst2_pcout", pcOut,               32'h0);
      check("rst2_count", fetchCount,          32'd0);
      reset = 1'b0;
      #1;
      check("rst2_rel_req",  {31'd0, imemReq}, 32'd1);
      check("rst2_rel_addr", imemAddr,         32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the byte address of the first fetch after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 imemReq  output  1  SHALL signal an instruction-memory read request.
REQ-005 imemAddr  output  32  SHALL carry the byte address of the request.
REQ-006 imemAck  input  1  SHALL indicate that imemData is valid for the current request; memory latency is one or more cycles.
REQ-007 imemData  input  32  SHALL carry the instruction word, sampled only when imemAck=1.
REQ-008 redirect  input  1  SHALL request a fetch redirect for a taken branch or jump.
REQ-009 redirectPc  input  32  SHALL carry the redirect target; bits [1:0] are ignored and treated as 00.
REQ-010 stall  input  1  SHALL indicate that decode cannot accept the held instruction this cycle.
REQ-011 instr  output  32  SHALL carry the held instruction word.
REQ-012 instrValid  output  1  SHALL be high when instr is valid for decode.
REQ-013 pcOut  output  32  SHALL carry the byte address of instr.
REQ-014 opcode  output  6  SHALL equal instr[31:26]; funct  output  6  SHALL equal instr[5:0]. Both drive the control unit's opcode/funct inputs.
REQ-015 fetchCount  output  32  SHALL count instructions delivered to decode.

Function
REQ-016 The FSM SHALL have exactly three states: REQ (request outstanding), VALID (instruction held), and DISCARD (stale request outstanding).
REQ-017 Register pc SHALL hold the next fetch address; imemAddr SHALL equal pc in REQ and the latched stale address in DISCARD.
REQ-018 imemReq SHALL be 1 in REQ and DISCARD and 0 in VALID; imemAddr SHALL stay stable while imemReq=1 and imemAck=0.
REQ-019 REQ, imemAck=1, redirect=0: instr<=imemData, pcOut<=pc, pc<=pc+4 modulo 2^32, go to VALID (instrValid=1 next cycle).
REQ-020 REQ, imemAck=1, redirect=1: data SHALL be dropped, pc<=redirectPc&~3, and the FSM SHALL stay in REQ.
REQ-021 REQ, imemAck=0, redirect=1: the stale address SHALL be latched, pc<=redirectPc&~3, go to DISCARD.
REQ-022 DISCARD: imemData SHALL never be captured; a further redirect SHALL overwrite pc (latest wins). On imemAck=1, go to REQ.
REQ-023 VALID, redirect=1: instrValid<=0, pc<=redirectPc&~3, go to REQ; redirect SHALL take priority over stall.
REQ-024 VALID, stall=1, redirect=0: instr, pcOut and instrValid SHALL hold unchanged.
REQ-025 VALID, stall=0, redirect=0: the instruction SHALL be consumed, fetchCount SHALL increment by 1 (wrapping at 2^32), instrValid<=0, go to REQ.
REQ-026 fetchCount SHALL increment only under REQ-025.
REQ-027 Throughput SHALL be one instruction per (memory latency + 1) cycles at most.
REQ-028 instrValid SHALL never be 1 in REQ or DISCARD.

Reset
REQ-029 While reset=1: state<=REQ, pc<=RESET_PC, instr<=0, pcOut<=RESET_PC, instrValid<=0, fetchCount<=0, and imemReq SHALL be forced to 0.
REQ-030 Reset SHALL override every other input, including reset asserted mid-request. Any imemAck arriving during reset, or in the first cycle after reset, for a pre-reset request SHALL be the memory's responsibility to suppress; the block SHALL simply restart at RESET_PC.

Verification
REQ-031 Reset, then 1-cycle-latency memory returning 32'h0000_0020 (add) at address 0 with stall=0. Required: imemAddr=0, then instrValid=1, instr=32'h0000_0020, opcode=0, funct=32, pcOut=0; next imemAddr=4; fetchCount=1.
REQ-032 Instruction held with stall=1 for 3 cycles. Required: instr and pcOut stable, imemReq=0, fetchCount unchanged; released one cycle after stall=0.
REQ-033 REQ at address 8 with 3-cycle latency, redirect=1 with redirectPc=32'h0000_0043 in cycle 1. Required: imemAddr stays 8 until ack, data dropped, then imemAddr=32'h40, no instrValid pulse.
REQ-034 VALID with stall=1 and redirect=1 (redirectPc=32'h100) in the same cycle. Required: instrValid=0 next cycle, next imemAddr=32'h100, fetchCount unchanged.
REQ-035 pc=32'hFFFF_FFFC fetched. Required: next imemAddr=32'h0000_0000.
REQ-036 Reset asserted while in DISCARD. Required: next cycle all outputs at reset values; first request after release at RESET_PC.
